// File: rtl/gelato_simt_stack.sv
// gelato_simt_stack: per-warp SIMT reconvergence stack.
// Each warp holds up to STACK_DEPTH {pc, rpc, mask} entries. Decode issues
// ADVANCE / SPLIT / EXIT commands, and the fetch scheduler reads each warp's
// top-of-stack pc and mask.
module gelato_simt_stack #(
   parameter  int WARP_NUM    = 4,
   parameter  int THREAD_NUM  = 32,
   parameter  int STACK_DEPTH = 8,
   parameter  int PC_WIDTH    = 32,
   localparam int WID_W       = $clog2(WARP_NUM),
   localparam int DEP_W       = $clog2(STACK_DEPTH + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rdy,
   input  logic                           init_valid,
   input  logic [WID_W-1:0]               init_warp,
   input  logic [PC_WIDTH-1:0]            init_pc,
   input  logic [THREAD_NUM-1:0]          init_mask,
   input  logic                           upd_valid,
   output logic                           upd_ready,
   input  logic [WID_W-1:0]               upd_warp,
   input  logic [1:0]                     upd_op,
   input  logic [PC_WIDTH-1:0]            upd_pc,
   input  logic [PC_WIDTH-1:0]            upd_taken_pc,
   input  logic [THREAD_NUM-1:0]          upd_taken_mask,
   input  logic [PC_WIDTH-1:0]            upd_rpc,
   output logic [THREAD_NUM-1:0]          upd_mask,
   output logic [WARP_NUM-1:0]            sel_valid,
   output logic [WARP_NUM*PC_WIDTH-1:0]   sel_pc,
   output logic [WARP_NUM*THREAD_NUM-1:0] sel_mask,
   output logic [WARP_NUM*DEP_W-1:0]      sel_depth,
   output logic [WARP_NUM-1:0]            ovf
);

   localparam int IDX_W = $clog2(STACK_DEPTH);

   typedef enum logic [1:0] {
      OP_ADVANCE = 2'b00,
      OP_SPLIT   = 2'b01,
      OP_EXIT    = 2'b10,
      OP_RSVD    = 2'b11
   } op_e;

   // Index of the top entry; an empty stack maps to entry 0 so reads stay in range.
   function automatic logic [IDX_W-1:0] top_idx(input logic [DEP_W-1:0] depth);
      logic [DEP_W-1:0] dm1;
      dm1 = (depth == '0) ? '0 : depth - DEP_W'(1);
      return IDX_W'(dm1);
   endfunction

   logic [PC_WIDTH-1:0]   pc_q    [WARP_NUM][STACK_DEPTH];
   logic [PC_WIDTH-1:0]   pc_d    [WARP_NUM][STACK_DEPTH];
   logic [PC_WIDTH-1:0]   rpc_q   [WARP_NUM][STACK_DEPTH];
   logic [PC_WIDTH-1:0]   rpc_d   [WARP_NUM][STACK_DEPTH];
   logic [THREAD_NUM-1:0] mask_q  [WARP_NUM][STACK_DEPTH];
   logic [THREAD_NUM-1:0] mask_d  [WARP_NUM][STACK_DEPTH];
   logic [DEP_W-1:0]      depth_q [WARP_NUM];
   logic [DEP_W-1:0]      depth_d [WARP_NUM];
   logic [WARP_NUM-1:0]   ovf_q;
   logic [WARP_NUM-1:0]   ovf_d;

   logic                  upd_fire;
   logic [DEP_W-1:0]      u_depth;
   logic [IDX_W-1:0]      u_top;
   logic [IDX_W-1:0]      u_push0;
   logic [IDX_W-1:0]      u_push1;
   logic [THREAD_NUM-1:0] u_top_mask;
   logic [THREAD_NUM-1:0] t_mask;
   logic [THREAD_NUM-1:0] n_mask;

   // Init to the same warp wins over a decode command in the same cycle.
   assign upd_ready = rdy & ~(init_valid & (init_warp == upd_warp));
   assign upd_fire  = upd_valid & upd_ready;

   // Decode-side view of the addressed warp's top entry.
   assign u_depth    = depth_q[upd_warp];
   assign u_top      = top_idx(u_depth);
   assign u_push0    = IDX_W'(u_depth);
   assign u_push1    = IDX_W'(u_depth + DEP_W'(1));
   assign u_top_mask = mask_q[upd_warp][u_top];
   assign t_mask     = upd_taken_mask & u_top_mask;
   assign n_mask     = u_top_mask & ~t_mask;
   assign upd_mask   = (u_depth != '0) ? u_top_mask : '0;
   assign ovf        = ovf_q;

   // Next-state for all stacks: apply the accepted command, then any warp launch.
   // NOTE: every *_d starts as a copy of its *_q so that no path through the
   // case statement leaves a variable unassigned and infers a latch.
   always_comb begin
      pc_d    = pc_q;
      rpc_d   = rpc_q;
      mask_d  = mask_q;
      depth_d = depth_q;
      ovf_d   = ovf_q;

      if (upd_fire && (u_depth != '0)) begin
         case (op_e'(upd_op))
            OP_ADVANCE: begin
               if ((u_depth > DEP_W'(1)) && (upd_pc == rpc_q[upd_warp][u_top])) begin
                  depth_d[upd_warp] = u_depth - DEP_W'(1);
               end else begin
                  pc_d[upd_warp][u_top] = upd_pc;
               end
            end
            OP_SPLIT: begin
               if (t_mask == '0) begin
                  pc_d[upd_warp][u_top] = upd_pc;
               end else if (n_mask == '0) begin
                  pc_d[upd_warp][u_top] = upd_taken_pc;
               end else if (int'(u_depth) + 2 <= STACK_DEPTH) begin
                  // Current top becomes the reconvergence entry; taken path on top.
                  pc_d[upd_warp][u_top]     = upd_rpc;
                  pc_d[upd_warp][u_push0]   = upd_pc;
                  rpc_d[upd_warp][u_push0]  = upd_rpc;
                  mask_d[upd_warp][u_push0] = n_mask;
                  pc_d[upd_warp][u_push1]   = upd_taken_pc;
                  rpc_d[upd_warp][u_push1]  = upd_rpc;
                  mask_d[upd_warp][u_push1] = t_mask;
                  depth_d[upd_warp]         = u_depth + DEP_W'(2);
               end else begin
                  ovf_d[upd_warp] = 1'b1;
               end
            end
            OP_EXIT: begin
               if (u_depth > DEP_W'(1)) begin
                  depth_d[upd_warp] = u_depth - DEP_W'(1);
               end else begin
                  mask_d[upd_warp][u_top] = '0;
               end
            end
            default: ;
         endcase
      end

      if (rdy && init_valid) begin
         depth_d[init_warp]   = DEP_W'(1);
         pc_d[init_warp][0]   = init_pc;
         rpc_d[init_warp][0]  = '1;
         mask_d[init_warp][0] = init_mask;
         ovf_d[init_warp]     = 1'b0;
      end
   end

   // State register; rdy gating is already folded into the next-state logic.
   // NOTE: the entry arrays are reset as well, because the stacks must read
   // back as all-zero after reset, not just the depth counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int w = 0; w < WARP_NUM; w++) begin
            for (int e = 0; e < STACK_DEPTH; e++) begin
               pc_q[w][e]   <= '0;
               rpc_q[w][e]  <= '0;
               mask_q[w][e] <= '0;
            end
            depth_q[w] <= '0;
         end
         ovf_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop
         // samples the pre-edge values regardless of statement order.
         pc_q    <= pc_d;
         rpc_q   <= rpc_d;
         mask_q  <= mask_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
      end
   end

   // Fetch-scheduler view: flattened top-of-stack pc, mask and depth per warp.
   always_comb begin
      sel_valid = '0;
      sel_pc    = '0;
      sel_mask  = '0;
      sel_depth = '0;
      for (int w = 0; w < WARP_NUM; w++) begin
         if (depth_q[w] != '0) begin
            sel_pc[w*PC_WIDTH +: PC_WIDTH]       = pc_q[w][top_idx(depth_q[w])];
            sel_mask[w*THREAD_NUM +: THREAD_NUM] = mask_q[w][top_idx(depth_q[w])];
            sel_valid[w]                         = |mask_q[w][top_idx(depth_q[w])];
         end
         sel_depth[w*DEP_W +: DEP_W] = depth_q[w];
      end
   end

endmodule
